// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector: takes a (width, height) header then row-major
// pixels, and emits one saturated |Gx|+|Gy| byte per interior pixel.
module sobel_stream_filter #(
  parameter int unsigned MAX_WIDTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in
);

  localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned GW = 12;

  typedef enum logic [1:0] {GET_W, GET_H, PIXELS} state_t;

  state_t      state, state_next;
  logic [7:0]  width, width_next, height, height_next;
  logic [7:0]  row, row_next, col, col_next;
  logic        accept_c, produce_c;

  logic [7:0]  lb1 [MAX_WIDTH];
  logic [7:0]  lb2 [MAX_WIDTH];
  logic [AW-1:0] idx;
  logic [7:0]  top, mid;
  logic [7:0]  w0a, w0b, w1a, w1b, w2a, w2b;

  logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg, ax, ay, mag;
  logic signed [GW-1:0] gx, gy;
  logic [7:0]           sat;

  assign ready_out = !rst && !(valid_out && !ready_in);
  assign accept_c  = valid_in && ready_out;
  assign produce_c = accept_c && (state == PIXELS) && (row >= 8'd2) && (col >= 8'd2);

  assign idx = AW'(col);
  assign top = lb2[idx];
  assign mid = lb1[idx];

  // Header capture and frame position tracking
  always_comb begin
    state_next  = state;
    width_next  = width;
    height_next = height;
    row_next    = row;
    col_next    = col;
    if (accept_c) begin
      case (state)
        GET_W: begin
          width_next = data_in;
          state_next = GET_H;
        end
        GET_H: begin
          height_next = data_in;
          row_next    = 8'd0;
          col_next    = 8'd0;
          state_next  = (width == 8'd0 || data_in == 8'd0) ? GET_W : PIXELS;
        end
        PIXELS: begin
          if (col == width - 8'd1) begin
            col_next = 8'd0;
            if (row == height - 8'd1) begin
              row_next   = 8'd0;
              state_next = GET_W;
            end else begin
              row_next = row + 8'd1;
            end
          end else begin
            col_next = col + 8'd1;
          end
        end
        default: state_next = GET_W;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= GET_W;
      width  <= 8'd0;
      height <= 8'd0;
      row    <= 8'd0;
      col    <= 8'd0;
    end else begin
      state  <= state_next;
      width  <= width_next;
      height <= height_next;
      row    <= row_next;
      col    <= col_next;
    end
  end

  // Line buffers and the two trailing window columns; contents need no reset
  always_ff @(posedge clk) begin
    if (accept_c && state == PIXELS) begin
      lb2[idx] <= mid;
      lb1[idx] <= data_in;
      w0a <= (col == 8'd0) ? 8'd0 : w0b;
      w1a <= (col == 8'd0) ? 8'd0 : w1b;
      w2a <= (col == 8'd0) ? 8'd0 : w2b;
      w0b <= top;
      w1b <= mid;
      w2b <= data_in;
    end
  end

  // Window columns: a = c-2, b = c-1, live column = c (top, mid, data_in)
  always_comb begin
    gx_pos = GW'(top) + (GW'(mid) << 1) + GW'(data_in);
    gx_neg = GW'(w0a) + (GW'(w1a) << 1) + GW'(w2a);
    gy_pos = GW'(w2a) + (GW'(w2b) << 1) + GW'(data_in);
    gy_neg = GW'(w0a) + (GW'(w0b) << 1) + GW'(top);
    gx     = signed'(gx_pos - gx_neg);
    gy     = signed'(gy_pos - gy_neg);
    ax     = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay     = gy[GW-1] ? GW'(-gy) : GW'(gy);
    mag    = ax + ay;
    sat    = (mag > GW'(255)) ? 8'hFF : mag[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= 8'd0;
    end else if (produce_c) begin
      valid_out <= 1'b1;
      data_out  <= sat;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter: table of frames, scoreboard of
// model-computed gradients, plus stall and mid-frame reset sequences.
module tb_sobel_stream_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;

  sobel_stream_filter #(.MAX_WIDTH(256)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int h;
    int pat;
    bit stall;
    int exp_count;
    int exp_val;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int out_cnt = 0;
  int cur_exp = -1;
  int sb [$];
  int img [8][8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0: return 5 * r + c;
      1: return 100;
      2: return (c == 2) ? 255 : 0;
      default: return 7;
    endcase
  endfunction

  function automatic int sobel(input int r, input int c);
    int p [3][3];
    int gx, gy, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-2+i][c-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // Output monitor: scoreboard pop on each output transfer
  always @(negedge clk) begin
    #1;
    if (!rst && valid_out && ready_in) begin
      out_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got data_out %0d, expected no output", data_out);
      end else begin
        check("data_out", int'(data_out), sb.pop_front());
        if (cur_exp >= 0) check("table_value", int'(data_out), cur_exp);
      end
    end
  end

  task automatic send_byte(input int b);
    int g;
    @(negedge clk);
    data_in  = 8'(b);
    valid_in = 1'b1;
    #1;
    g = 0;
    while (!ready_out && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 1000) check("send_timeout", g, 0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int pat, input int npix);
    int n;
    n = 0;
    send_byte(w);
    send_byte(h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (n < npix) begin
          img[r][c] = pix(pat, r, c);
          if (r >= 2 && c >= 2) sb.push_back(sobel(r, c));
          send_byte(img[r][c]);
          n++;
        end
      end
    idle();
  endtask

  task automatic stall_watch(input int val);
    int g;
    g = 0;
    while (!valid_out && g < 500) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("stall_wait_valid", int'(valid_out), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("stall_data_hold", int'(data_out), val);
      check("stall_valid_hold", int'(valid_out), 1);
      check("stall_ready_low", int'(ready_out), 0);
    end
    @(negedge clk);
    ready_in = 1'b1;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{w:5, h:4, pat:0, stall:1'b0, exp_count:6, exp_val:48};
    vecs[1] = '{w:3, h:3, pat:1, stall:1'b0, exp_count:1, exp_val:0};
    vecs[2] = '{w:3, h:3, pat:2, stall:1'b0, exp_count:1, exp_val:255};
    vecs[3] = '{w:5, h:4, pat:0, stall:1'b1, exp_count:6, exp_val:48};
    vecs[4] = '{w:2, h:2, pat:3, stall:1'b0, exp_count:0, exp_val:-1};
    vecs[5] = '{w:3, h:3, pat:3, stall:1'b0, exp_count:1, exp_val:0};

    rst = 1'b1; valid_in = 1'b0; data_in = 8'd0; ready_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_data_out", int'(data_out), 0);
    check("reset_ready_out", int'(ready_out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_ready_out", int'(ready_out), 1);

    for (int i = 0; i < 6; i++) begin
      out_cnt = 0;
      cur_exp = vecs[i].exp_val;
      if (vecs[i].stall) begin
        ready_in = 1'b0;
        fork
          send_frame(vecs[i].w, vecs[i].h, vecs[i].pat, vecs[i].w * vecs[i].h);
          stall_watch(vecs[i].exp_val);
        join
      end else begin
        send_frame(vecs[i].w, vecs[i].h, vecs[i].pat, vecs[i].w * vecs[i].h);
      end
      repeat (5) @(negedge clk);
      check($sformatf("out_count_frame%0d", i), out_cnt, vecs[i].exp_count);
      check($sformatf("sb_empty_frame%0d", i), sb.size(), 0);
    end

    // Abandon a 5x4 frame after 7 pixels, then a fresh 3x3 edge frame
    out_cnt = 0;
    cur_exp = -1;
    send_frame(5, 4, 0, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midreset_valid_out", int'(valid_out), 0);
    check("midreset_ready_out", int'(ready_out), 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    check("after_reset_valid_out", int'(valid_out), 0);
    out_cnt = 0;
    cur_exp = 255;
    send_frame(3, 3, 2, 9);
    repeat (5) @(negedge clk);
    check("out_count_after_reset", out_cnt, 1);
    check("sb_empty_after_reset", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
